pc_gen_unit: RTL and testbench

- Parametrised program-counter generator; successor to the single-cycle PC register.
- Holds the architectural PC and offers it to the IFU over a valid/ready handshake.
- Waits for the WBU commit, then computes the next PC from the commit mode: sequential, jal, jalr, branch, or CSR/trap target.
- Adds a configurable reset vector, configurable instruction alignment with misalignment trapping, and an explicit issue/wait state machine.

---
 rtl/pc_gen_unit.sv | 225 ++++++++++++++++++++++
 tb/tb_pc_gen_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen_unit.sv
// -----------------------------------------------------------------------------
// pc_gen_unit
//
// Program-counter generator. Holds the architectural PC, offers it to the
// instruction fetch unit over a valid/ready handshake, then waits for the
// write-back unit to commit the instruction at that PC before computing the
// next PC from the commit mode (seq, jal, jalr, branch, csr/trap target).
// Computed targets that violate the configured instruction alignment are
// replaced by TRAP_VEC and flagged with a one-cycle misalign pulse.
//
// Optional feature macro: PC_GEN_PERF_EN
//   defined   -> commit_cnt / redirect_cnt performance counters are built
//   undefined -> both counter outputs are tied to zero, no counter flops
//
// Parameters:
//   XLEN       datapath and PC width
//   RESET_VEC  PC loaded on reset
//   TRAP_VEC   PC loaded when a computed target is misaligned
//   IALIGN     instruction alignment in bits (32 -> target[1:0], 16 -> target[0])
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   pc            out  current PC
//   pc_valid      out  PC offered to the IFU
//   pc_ready      in   IFU accepts the PC
//   commit_valid  in   WBU commit of the instruction at pc
//   commit_ready  out  unit is able to take a commit
//   pc_sel        in   next-PC mode (001 jalr, 010 jal, 100 branch, 101 csr,
//                      110 seq, anything else holds the PC)
//   rs1_data      in   jalr base
//   imm_data      in   jal/jalr/branch offset
//   br_taken      in   branch condition result
//   csr_target    in   mtvec/mepc target
//   misalign      out  one-cycle pulse after a commit with a misaligned target
//   redirect_cnt  out  count of non-sequential PC changes
//   commit_cnt    out  count of accepted commits
// -----------------------------------------------------------------------------
module pc_gen_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h8000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h8000_0004,
  parameter int unsigned     IALIGN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] pc,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic            commit_valid,
  output logic            commit_ready,
  input  logic [2:0]      pc_sel,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] imm_data,
  input  logic            br_taken,
  input  logic [XLEN-1:0] csr_target,
  output logic            misalign,
  output logic [31:0]     redirect_cnt,
  output logic [31:0]     commit_cnt
);

  localparam logic [2:0] SEL_JALR   = 3'b001;
  localparam logic [2:0] SEL_JAL    = 3'b010;
  localparam logic [2:0] SEL_BRANCH = 3'b100;
  localparam logic [2:0] SEL_CSR    = 3'b101;
  localparam logic [2:0] SEL_SEQ    = 3'b110;

  typedef enum logic {
    ST_ISSUE = 1'b0,
    ST_WAIT  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic            check_align;
  logic            target_bad;
  logic            commit_fire;

  // Alignment test on a candidate target. With compressed instructions
  // (IALIGN=16) only bit 0 matters; otherwise the low two bits must be zero.
  function automatic logic addr_misaligned(input logic [XLEN-1:0] addr);
    if (IALIGN == 16) begin
      return addr[0];
    end else begin
      return |addr[1:0];
    end
  endfunction

  assign commit_fire = (state_q == ST_WAIT) && commit_valid;

  // Target selection. Arithmetic wraps modulo 2^XLEN by construction.
  always_comb begin
    seq_pc      = pc_q + XLEN'(4);
    jalr_sum    = rs1_data + imm_data;
    target      = pc_q;
    check_align = 1'b0;
    case (pc_sel)
      SEL_JALR: begin
        // Bit 0 is cleared before the alignment test, so with IALIGN=16 a
        // jalr target can never trap.
        target      = {jalr_sum[XLEN-1:1], 1'b0};
        check_align = 1'b1;
      end
      SEL_JAL: begin
        target      = pc_q + imm_data;
        check_align = 1'b1;
      end
      SEL_BRANCH: begin
        if (br_taken) begin
          target      = pc_q + imm_data;
          check_align = 1'b1;
        end else begin
          target      = seq_pc;
        end
      end
      SEL_CSR: begin
        target      = csr_target;
        check_align = 1'b1;
      end
      SEL_SEQ: begin
        target      = seq_pc;
      end
      default: begin
        // Hold: the same PC is simply reissued.
        target      = pc_q;
      end
    endcase
    target_bad = check_align && addr_misaligned(target);
  end

  // Issue/wait sequencing and PC update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        // pc is frozen here; commit_valid is ignored.
        if (pc_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // pc_ready is ignored here. A commit_valid held high is consumed
        // once because the state immediately returns to ISSUE.
        if (commit_valid) begin
          state_d    = ST_ISSUE;
          pc_d       = target_bad ? TRAP_VEC : target;
          misalign_d = target_bad;
        end
      end
      default: begin
        state_d = ST_ISSUE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ISSUE;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc           = pc_q;
  assign misalign     = misalign_q;
  // The state register already sits in ISSUE during reset; qualifying with
  // rst keeps the PC from being offered until reset is released.
  assign pc_valid     = (state_q == ST_ISSUE) && !rst;
  assign commit_ready = (state_q == ST_WAIT);

`ifdef PC_GEN_PERF_EN
  logic [31:0] commit_cnt_q, commit_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;
  logic        redirect_fire;

  // A redirect is any commit that leaves the sequential path, including a
  // trap to TRAP_VEC caused by a misaligned target.
  assign redirect_fire = commit_fire &&
                         ((pc_sel == SEL_JAL) || (pc_sel == SEL_JALR) ||
                          (pc_sel == SEL_CSR) ||
                          ((pc_sel == SEL_BRANCH) && br_taken) ||
                          target_bad);

  always_comb begin
    commit_cnt_d   = commit_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (commit_fire) begin
      commit_cnt_d = commit_cnt_q + 32'd1;
    end
    if (redirect_fire) begin
      redirect_cnt_d = redirect_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_cnt_q   <= '0;
      redirect_cnt_q <= '0;
    end else begin
      commit_cnt_q   <= commit_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign commit_cnt   = commit_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`else
  logic unused_fire;
  assign unused_fire  = commit_fire;
  assign commit_cnt   = '0;
  assign redirect_cnt = '0;
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_gen_unit
//
// Directed bench for pc_gen_unit. Two instances share all inputs: dut uses
// IALIGN=32, dut16 uses IALIGN=16, so the alignment behaviour of both
// configurations can be compared on the same commit.
// -----------------------------------------------------------------------------
module tb_pc_gen_unit;

`ifdef PC_GEN_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        pc_ready;
  logic        commit_valid;
  logic [2:0]  pc_sel;
  logic [31:0] rs1_data;
  logic [31:0] imm_data;
  logic        br_taken;
  logic [31:0] csr_target;

  logic [31:0] pc, redirect_cnt, commit_cnt;
  logic        pc_valid, commit_ready, misalign;
  logic [31:0] pc16, redirect_cnt16, commit_cnt16;
  logic        pc_valid16, commit_ready16, misalign16;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [31:0] exp_commit   = 32'd0;
  logic [31:0] exp_redirect = 32'd0;

  pc_gen_unit #(.XLEN(32), .RESET_VEC(32'h8000_0000), .TRAP_VEC(32'h8000_0004),
                .IALIGN(32)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .commit_valid(commit_valid), .commit_ready(commit_ready), .pc_sel(pc_sel),
    .rs1_data(rs1_data), .imm_data(imm_data), .br_taken(br_taken),
    .csr_target(csr_target), .misalign(misalign),
    .redirect_cnt(redirect_cnt), .commit_cnt(commit_cnt)
  );

  pc_gen_unit #(.XLEN(32), .RESET_VEC(32'h8000_0000), .TRAP_VEC(32'h8000_0004),
                .IALIGN(16)) dut16 (
    .clk(clk), .rst(rst), .pc(pc16), .pc_valid(pc_valid16), .pc_ready(pc_ready),
    .commit_valid(commit_valid), .commit_ready(commit_ready16), .pc_sel(pc_sel),
    .rs1_data(rs1_data), .imm_data(imm_data), .br_taken(br_taken),
    .csr_target(csr_target), .misalign(misalign16),
    .redirect_cnt(redirect_cnt16), .commit_cnt(commit_cnt16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string tag);
    check_val({tag, "_commit_cnt"}, commit_cnt, PERF ? exp_commit : 32'd0);
    check_val({tag, "_redirect_cnt"}, redirect_cnt, PERF ? exp_redirect : 32'd0);
  endtask

  // Full handshake from ISSUE: IFU accepts, then one commit in WAIT.
  task automatic do_commit(input logic [2:0] sel, input logic [31:0] rs1,
                           input logic [31:0] imm, input logic br,
                           input logic [31:0] csr, input logic bad32);
    pc_ready = 1'b1;
    step();
    pc_ready = 1'b0;
    check_val("wait_pc_valid", {31'd0, pc_valid}, 32'd0);
    check_val("wait_commit_ready", {31'd0, commit_ready}, 32'd1);
    pc_sel       = sel;
    rs1_data     = rs1;
    imm_data     = imm;
    br_taken     = br;
    csr_target   = csr;
    commit_valid = 1'b1;
    step();
    commit_valid = 1'b0;
    pc_sel       = 3'b000;
    exp_commit   = exp_commit + 32'd1;
    if (sel == 3'b001 || sel == 3'b010 || sel == 3'b101 ||
        (sel == 3'b100 && br) || bad32) begin
      exp_redirect = exp_redirect + 32'd1;
    end
    check_val("issue_pc_valid", {31'd0, pc_valid}, 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    pc_ready     = 1'b0;
    commit_valid = 1'b0;
    pc_sel       = 3'b000;
    rs1_data     = 32'd0;
    imm_data     = 32'd0;
    br_taken     = 1'b0;
    csr_target   = 32'd0;

    // Reset state
    step();
    step();
    check_val("rst_pc", pc, 32'h8000_0000);
    check_val("rst_pc_valid", {31'd0, pc_valid}, 32'd0);
    check_val("rst_commit_ready", {31'd0, commit_ready}, 32'd0);
    check_val("rst_misalign", {31'd0, misalign}, 32'd0);
    check_cnts("rst");
    rst = 1'b0;
    #1;
    check_val("post_rst_pc_valid", {31'd0, pc_valid}, 32'd1);
    check_val("post_rst_commit_ready", {31'd0, commit_ready}, 32'd0);

    // Sequential commit
    do_commit(3'b110, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    check_val("seq_pc", pc, 32'h8000_0004);
    check_cnts("seq");

    // jal to 0x8000_0010
    do_commit(3'b010, 32'd0, 32'h0000_000C, 1'b0, 32'd0, 1'b0);
    check_val("jal_pc", pc, 32'h8000_0010);
    check_val("jal_pc16", pc16, 32'h8000_0010);

    // Taken backward branch
    do_commit(3'b100, 32'd0, 32'hFFFF_FFF0, 1'b1, 32'd0, 1'b0);
    check_val("br_taken_pc", pc, 32'h8000_0000);
    check_cnts("br_taken");

    // Back to 0x8000_0010, then not-taken branch
    do_commit(3'b010, 32'd0, 32'h0000_0010, 1'b0, 32'd0, 1'b0);
    check_val("jal2_pc", pc, 32'h8000_0010);
    do_commit(3'b100, 32'd0, 32'hFFFF_FFF0, 1'b0, 32'd0, 1'b0);
    check_val("br_nt_pc", pc, 32'h8000_0014);
    check_cnts("br_nt");

    // jalr to 0x8000_0102: legal at IALIGN=16, traps at IALIGN=32
    do_commit(3'b001, 32'h8000_0101, 32'h0000_0002, 1'b0, 32'd0, 1'b1);
    check_val("jalr_pc32", pc, 32'h8000_0004);
    check_val("jalr_misalign32", {31'd0, misalign}, 32'd1);
    check_val("jalr_pc16", pc16, 32'h8000_0102);
    check_val("jalr_misalign16", {31'd0, misalign16}, 32'd0);
    check_cnts("jalr");
    step();
    check_val("misalign_pulse_end", {31'd0, misalign}, 32'd0);
    check_val("trap_pc_stable", pc, 32'h8000_0004);

    // csr target realigns both instances
    do_commit(3'b101, 32'd0, 32'd0, 1'b0, 32'h8000_0100, 1'b0);
    check_val("csr_pc", pc, 32'h8000_0100);
    check_val("csr_pc16", pc16, 32'h8000_0100);

    // commit_valid during ISSUE is ignored
    commit_valid = 1'b1;
    pc_sel       = 3'b110;
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("issue_commit_ignored_pc", pc, 32'h8000_0100);
      check_val("issue_commit_ignored_vld", {31'd0, pc_valid}, 32'd1);
    end
    commit_valid = 1'b0;
    pc_sel       = 3'b000;
    check_cnts("issue_ignore");

    // Hold mode reissues the same PC
    do_commit(3'b000, 32'd0, 32'h0000_0040, 1'b1, 32'h1234_5678, 1'b0);
    check_val("hold_pc", pc, 32'h8000_0100);
    check_cnts("hold");

    // IFU stall: pc_valid and pc held for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check_val("stall_pc_valid", {31'd0, pc_valid}, 32'd1);
      check_val("stall_pc", pc, 32'h8000_0100);
    end

    // PC wrap-around
    do_commit(3'b101, 32'd0, 32'd0, 1'b0, 32'hFFFF_FFFC, 1'b0);
    check_val("csr_top_pc", pc, 32'hFFFF_FFFC);
    do_commit(3'b110, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    check_val("wrap_pc", pc, 32'h0000_0000);

    // csr target with bit 0 set traps in both configurations
    do_commit(3'b101, 32'd0, 32'd0, 1'b0, 32'h0000_0003, 1'b1);
    check_val("csr_bad_pc32", pc, 32'h8000_0004);
    check_val("csr_bad_pc16", pc16, 32'h8000_0004);
    check_val("csr_bad_misalign16", {31'd0, misalign16}, 32'd1);
    check_cnts("csr_bad");

`ifdef PC_GEN_PERF_EN
    // Commit counter wrap
    force dut.commit_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.commit_cnt_q;
    exp_commit = 32'hFFFF_FFFF;
    do_commit(3'b110, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    check_val("cnt_wrap", commit_cnt, 32'd0);
    check_val("cnt_wrap_pc", pc, 32'h8000_0008);
`endif

    // Asynchronous reset asserted mid-WAIT
    pc_ready = 1'b1;
    step();
    pc_ready = 1'b0;
    check_val("pre_arst_commit_ready", {31'd0, commit_ready}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_pc", pc, 32'h8000_0000);
    check_val("arst_commit_ready", {31'd0, commit_ready}, 32'd0);
    check_val("arst_pc_valid", {31'd0, pc_valid}, 32'd0);
    exp_commit   = 32'd0;
    exp_redirect = 32'd0;
    check_cnts("arst");
    step();
    rst = 1'b0;
    #1;
    check_val("arst_release_pc_valid", {31'd0, pc_valid}, 32'd1);
    check_val("arst_release_pc", pc, 32'h8000_0000);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
